// File: rtl/psum_drain_if.sv
// Lane stream from psum_drain toward the host or the next layer's ifm loader.
interface psum_drain_if #(
    parameter int LANE_W = 16
);
    logic [LANE_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/psum_drain.sv
// Walks out_buf after a layer completes and streams each packed psum word
// out as LANE_W-wide lanes, most significant lane first.
module psum_drain #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64,
    parameter int LANE_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       word_count,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    output logic [7:0]        ram_wea,
    input  logic [DATA_W-1:0] ram_dout,
    psum_drain_if.master      m,
    output logic              busy,
    output logic              done
);
    localparam int LANES      = DATA_W / LANE_W;
    localparam int LANE_IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        EMIT,
        FIN
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_W-1:0]     addr_q;
    logic [15:0]           words_left;
    logic [DATA_W-1:0]     shreg;
    logic [LANE_IDX_W-1:0] lane_idx;
    logic                  beat;
    logic                  last_lane;
    logic                  last_word;

    assign beat      = (state == EMIT) && m.m_ready;
    assign last_lane = (lane_idx == LANE_IDX_W'(LANES - 1));
    assign last_word = (words_left == 16'd1);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (word_count == '0) ? FIN : FETCH;
                end
            end
            FETCH: state_nxt = LOAD;
            LOAD:  state_nxt = EMIT;
            EMIT: begin
                if (beat && last_lane) begin
                    state_nxt = last_word ? FIN : FETCH;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address, remaining-word count and lane shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            words_left <= '0;
            shreg      <= '0;
            lane_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q     <= base_addr;
                        words_left <= word_count;
                        lane_idx   <= '0;
                    end
                end
                LOAD: begin
                    shreg    <= ram_dout;
                    lane_idx <= '0;
                end
                EMIT: begin
                    if (beat) begin
                        shreg    <= shreg << LANE_W;
                        lane_idx <= lane_idx + 1'b1;
                        if (last_lane && !last_word) begin
                            words_left <= words_left - 16'd1;
                            addr_q     <= addr_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        ram_en    = (state == FETCH);
        ram_addr  = (state == FETCH) ? addr_q : '0;
        ram_wea   = '0;
        m.m_valid = (state == EMIT);
        m.m_data  = (state == EMIT) ? shreg[DATA_W-1 -: LANE_W] : '0;
        m.m_last  = (state == EMIT) && last_lane && last_word;
        busy      = (state == FETCH) || (state == LOAD) || (state == EMIT);
        done      = (state == FIN);
    end
endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: directed timing cases plus randomized
// drains against a queue-based lane/address reference model.
module tb_psum_drain;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] word_count;
    logic [15:0] ram_addr;
    logic        ram_en;
    logic [7:0]  ram_wea;
    logic [63:0] ram_dout;
    logic        busy;
    logic        done;

    logic rand_ready = 1'b0;
    logic rnd_ready  = 1'b1;
    logic dir_ready  = 1'b1;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    logic [63:0] mem [0:65535];
    logic [15:0] exp_data [$];
    logic        exp_last [$];
    logic [15:0] exp_addr [$];

    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    psum_drain_if #(.LANE_W(16)) sif ();

    assign sif.m_ready = rand_ready ? rnd_ready : dir_ready;

    psum_drain #(.ADDR_W(16), .DATA_W(64), .LANE_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .ram_addr   (ram_addr),
        .ram_en     (ram_en),
        .ram_wea    (ram_wea),
        .ram_dout   (ram_dout),
        .m          (sif),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // out_buf model: one-cycle read latency.
    always @(posedge clk) begin
        if (ram_en) ram_dout <= mem[ram_addr];
    end

    // Random downstream readiness, mostly high.
    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ram_en"},   ram_en, 0);
        check({tag, "_ram_addr"}, ram_addr, 0);
        check({tag, "_ram_wea"},  ram_wea, 0);
        check({tag, "_m_data"},   sif.m_data, 0);
        check({tag, "_m_valid"},  sif.m_valid, 0);
        check({tag, "_m_last"},   sif.m_last, 0);
        check({tag, "_busy"},     busy, 0);
        check({tag, "_done"},     done, 0);
    endtask

    // Monitor: fetch addresses, beats, stall stability and done pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (ram_en) begin
                check("ram_wea", ram_wea, 0);
                check("fetch_pending", exp_addr.size() != 0, 1);
                if (exp_addr.size() != 0) check("fetch_addr", ram_addr, exp_addr.pop_front());
            end
            if (prev_stall) begin
                check("hold_valid", sif.m_valid, 1);
                check("hold_data", sif.m_data, prev_data);
                check("hold_last", sif.m_last, prev_last);
            end
            if (sif.m_last) check("last_with_valid", sif.m_valid, 1);
            if (sif.m_valid && sif.m_ready) begin
                check("beat_pending", exp_data.size() != 0, 1);
                if (exp_data.size() != 0) begin
                    check("beat_data", sif.m_data, exp_data.pop_front());
                    check("beat_last", sif.m_last, exp_last.pop_front());
                end
            end
            prev_stall = sif.m_valid && !sif.m_ready;
            prev_data  = sif.m_data;
            prev_last  = sif.m_last;
        end
    end

    // Pulse start; when accepted, the model expects every word of the drain.
    task automatic do_start(input logic [15:0] b, input logic [15:0] n, input bit accepted);
        logic [15:0] a;
        logic [63:0] w;
        @(negedge clk);
        start      = 1'b1;
        base_addr  = b;
        word_count = n;
        if (accepted) begin
            for (int i = 0; i < int'(n); i++) begin
                a = b + 16'(i);
                w = mem[a];
                exp_addr.push_back(a);
                for (int l = 0; l < 4; l++) begin
                    exp_data.push_back(w[63 - 16*l -: 16]);
                    exp_last.push_back((i == int'(n) - 1) && (l == 3));
                end
            end
        end
        @(posedge clk);
        #1;
        start      = 1'b0;
        base_addr  = 16'($urandom);
        word_count = 16'($urandom);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = done_cnt;
        int k  = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_done_seen"}, done_cnt != d0, 1);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_one_done"}, done_cnt - d0, 1);
        check({tag, "_lanes_left"}, exp_data.size(), 0);
        check({tag, "_fetches_left"}, exp_addr.size(), 0);
    endtask

    task automatic fill(input logic [15:0] b, input int n);
        for (int i = 0; i < n; i++) mem[b + 16'(i)] = {$urandom, $urandom};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int d0;
        logic [15:0] b;
        logic [15:0] n;

        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        // Single word: exact cycle timing.
        mem[16'h0010] = 64'h0001_0002_0003_0004;
        do_start(16'h0010, 16'd1, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check("t1_ram_en", ram_en, c == 1);
            if (c == 1) check("t1_ram_addr", ram_addr, 16'h0010);
            check("t1_valid", sif.m_valid, (c >= 3) && (c <= 6));
            if (c >= 3 && c <= 6) check("t1_data", sif.m_data, c - 2);
            check("t1_last", sif.m_last, c == 6);
            check("t1_busy", busy, c <= 6);
            check("t1_done", done, c == 7);
            @(posedge clk);
            #1;
        end
        check("t1_lanes_left", exp_data.size(), 0);

        // Backpressure during lane 1.
        do_start(16'h0010, 16'd1, 1'b1);
        for (int c = 1; c <= 11; c++) begin
            dir_ready = !(c >= 4 && c <= 6);
            @(negedge clk);
            check("t2_valid", sif.m_valid, (c >= 3) && (c <= 9));
            if (c >= 4 && c <= 7) check("t2_stall_data", sif.m_data, 16'h0002);
            check("t2_done", done, c == 10);
            @(posedge clk);
            #1;
        end
        dir_ready = 1'b1;
        check("t2_lanes_left", exp_data.size(), 0);

        // Zero count.
        do_start(16'h0200, 16'd0, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("t3_ram_en", ram_en, 0);
            check("t3_valid", sif.m_valid, 0);
            check("t3_busy", busy, 0);
            check("t3_done", done, c == 1);
            @(posedge clk);
            #1;
        end

        // Address wrap.
        mem[16'hFFFF] = {$urandom, $urandom};
        mem[16'h0000] = {$urandom, $urandom};
        do_start(16'hFFFF, 16'd2, 1'b1);
        wait_done("t4", 40);

        // Start while busy is ignored.
        fill(16'h0300, 2);
        fill(16'h0400, 5);
        do_start(16'h0300, 16'd2, 1'b1);
        k = 0;
        while (!sif.m_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t5_reached_emit", sif.m_valid, 1);
        do_start(16'h0400, 16'd5, 1'b0);
        wait_done("t5", 40);

        // Reset during lane 1 of a two-word drain.
        fill(16'h0500, 2);
        do_start(16'h0500, 16'd2, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            if (c == 4) rst_n = 1'b0;
            if (c == 5) begin
                rst_n = 1'b1;
                exp_data.delete();
                exp_last.delete();
                exp_addr.delete();
            end
            @(negedge clk);
            if (c == 5) check_idle("t6_after_rst");
            @(posedge clk);
            #1;
        end
        d0 = done_cnt;
        repeat (8) @(posedge clk);
        #1;
        check("t6_no_done", done_cnt - d0, 0);
        fill(16'h0A00, 3);
        do_start(16'h0A00, 16'd3, 1'b1);
        wait_done("t6_fresh", 60);

        // Randomized drains with random backpressure.
        rand_ready = 1'b1;
        for (int it = 0; it < 25; it++) begin
            b = 16'($urandom);
            n = 16'($urandom_range(0, 5));
            fill(b, int'(n));
            do_start(b, n, 1'b1);
            wait_done("rand", 60 + 60 * int'(n));
        end
        rand_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
